packet_output_scheduler: RTL
============================

Name: packet_output_scheduler

Overview:
- Shares one output link between 4 input-buffer requesters and grants whole packets, head flit through tail flit.
- Arbitration between packets is round-robin. Downstream flow control uses a credit counter.
- Sits between the per-port input FIFOs and the output-link register stage of the router. It drives the crossbar select for that output.

Parameters:
- DATA_W, 256, flit width in bits.
- CREDIT_MAX, 8, downstream buffer depth in flits, which is also the reset credit value.
- CREDIT_W, 4, credit counter width. Must satisfy 2^CREDIT_W > CREDIT_MAX.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  per-requester: flit available.
- req_tail  input  4  per-requester: current flit is a packet tail.
- req_data  input  4*DATA_W  per-requester flit. Requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  4  per-requester pop strobe. Combinational; at most one bit high.
- out_valid  output  1  registered flit valid toward the link.
- out_data  output  DATA_W  registered flit.
- out_tail  output  1  registered tail flag.
- out_src_sel  output  3  index (0-3) of the locked requester; 7 = no grant.
- credit_return  input  1  downstream freed one flit slot.
- credit_cnt  output  CREDIT_W  current credits.
- credit_err  output  1  sticky flag: credit returned while at CREDIT_MAX.

Behaviour:
- Reset values (rst high at a clock edge):
  - state=IDLE, grant=0000, last_winner=4'b1000 (so requester 0 has top priority first).
  - credit_cnt=CREDIT_MAX, credit_err=0.
  - out_valid=0, out_tail=0, out_data=0.
  - out_src_sel=7; req_ready=0 while rst is high.
- Reset wins over every other event in the same cycle.
- Reset mid-packet drops the lock. No tail is emitted.
- FSM states: IDLE, LOCK.
- IDLE:
  - req_ready=0.
  - If req_valid!=0 and credit_cnt>0: pick the first requester with req_valid high, searching circularly from the index after last_winner. Register its one-hot grant and go to LOCK.
  - Otherwise stay in IDLE.
  - Arbitration costs one cycle: the first pop happens at the earliest one cycle after req_valid rises.
- LOCK:
  - req_ready[g] = (credit_cnt>0) for granted index g; all other ready bits are 0.
  - A transfer occurs when req_valid[g] & req_ready[g]. On a transfer, next cycle: out_valid=1, out_data=req_data[g], out_tail=req_tail[g]. Without a transfer, out_valid=0.
  - Transfer with req_tail[g]=1: last_winner<=grant, grant<=0, state<=IDLE. There is one bubble cycle between packets.
  - The lock persists across req_valid gaps and across credit stalls. Non-granted requesters are never served mid-packet.
- out_src_sel reflects the current grant register: 0-3 in LOCK, 7 in IDLE. Grant values that are not one-hot map to 7.
- Credit rules:
  - Transfer only: credit_cnt-1.
  - credit_return only: credit_cnt+1, saturating at CREDIT_MAX.
  - Both in the same cycle: unchanged.
  - credit_return with credit_cnt==CREDIT_MAX and no transfer: count unchanged, credit_err<=1 (cleared only by rst).
  - credit_cnt never underflows, because ready is gated by credit_cnt>0.
- Round-robin wrap: last_winner=1000 searches order 0,1,2,3; last_winner=0010 searches order 2,3,0,1.
- Fairness: a continuously requesting port is served within 3 intervening packets.

Decomposition:
- Package sched_pkg contains:
  - state enum {IDLE, LOCK}.
  - SEL_INVALID=3'd7.
  - function onehot4_to_idx (returns 7 on a non-one-hot input).
- Sub-module rr_pick4: purely combinational. Inputs req[3:0] and last[3:0]; output one-hot pick[3:0] (0 if req=0). The block instantiates it once.

Test Plan:
- Reset then credits=8, only req 2 sends a 3-flit packet -> req_ready[2] high cycles 2-4, out_valid cycles 3-5, out_tail in cycle 5, out_src_sel=2 throughout LOCK then 7.
- All 4 requesters hold 1-flit packets continuously -> grant order 0,1,2,3,0, with one IDLE bubble between packets.
- Credits start at 2, req 1 sends a 4-flit packet, no credit_return -> two flits transfer, then req_ready[1]=0 while credit_cnt=0. One credit_return -> one more flit transfers. The lock holds on req 1 throughout, even with req 0 valid.
- Transfer and credit_return in the same cycle at credit_cnt=5 -> credit_cnt stays 5. credit_return at 8 with no transfer -> credit_cnt=8, credit_err=1.
- rst asserted in LOCK mid-packet -> next cycle state IDLE, out_src_sel=7, credit_cnt=8. After release, req 0 wins even if req 3 is also valid.

Source files
------------

// File: rtl/packet_output_scheduler_pkg.sv
// Shared types and helpers for the packet output scheduler: FSM state encoding,
// the "no grant" select code and the one-hot to index decode.
package sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } sched_state_e;

    localparam logic [2:0] SEL_INVALID = 3'd7;

    // Anything that is not exactly one-hot decodes to SEL_INVALID.
    function automatic logic [2:0] onehot4_to_idx(input logic [3:0] v);
        case (v)
            4'b0001: return 3'd0;
            4'b0010: return 3'd1;
            4'b0100: return 3'd2;
            4'b1000: return 3'd3;
            default: return SEL_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/packet_output_scheduler_if.sv
// Bundle between the four input FIFOs, the scheduler and the output link stage.
// Handshake: a flit moves from requester i when req_valid[i] & req_ready[i] at a
// rising clk edge; req_ready never depends on req_valid, and out_valid is a
// registered single-cycle strobe with no back-pressure (credits cover that).
interface packet_output_scheduler_if #(
    parameter int DATA_W   = 256,
    parameter int CREDIT_W = 4
);
    logic [3:0]          req_valid;
    logic [3:0]          req_tail;
    logic [4*DATA_W-1:0] req_data;
    logic [3:0]          req_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_tail;
    logic [2:0]          out_src_sel;
    logic                credit_return;
    logic [CREDIT_W-1:0] credit_cnt;
    logic                credit_err;

    modport slave (
        input  req_valid, req_tail, req_data, credit_return,
        output req_ready, out_valid, out_data, out_tail, out_src_sel,
               credit_cnt, credit_err
    );

    modport master (
        output req_valid, req_tail, req_data, credit_return,
        input  req_ready, out_valid, out_data, out_tail, out_src_sel,
               credit_cnt, credit_err
    );
endinterface

// File: rtl/packet_output_scheduler_rr_pick4.sv
// Combinational 4-way round-robin pick: first set bit of req searching circularly
// from the position after the one-hot last winner.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [3:0] last,
    output logic [3:0] pick
);
    logic [1:0] base;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        base  = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        pick  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (last[i]) base = 2'(i);
        end
        // k = 4 wraps back onto the last winner itself, so it is searched last.
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/packet_output_scheduler.sv
// Output-port scheduler: round-robin packet-granular arbitration of four requesters
// onto one link, with credit-based downstream flow control and crossbar select.
module packet_output_scheduler
    import sched_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int CREDIT_MAX = 8,
    parameter int CREDIT_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    packet_output_scheduler_if.slave     bus,
    output sched_state_e                 dbg_state
);
    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);

    sched_state_e        state;
    logic [3:0]          grant;
    logic [3:0]          last_winner;
    logic [3:0]          pick;
    logic [3:0]          ready;
    logic [CREDIT_W-1:0] credit;
    logic                credit_ok;
    logic                xfer;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_tail;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_tail_q;
    logic                credit_err_q;

    rr_pick4 u_pick (
        .req  (bus.req_valid),
        .last (last_winner),
        .pick (pick)
    );

    assign credit_ok = (credit != '0);

    // Ready is gated by credits so the counter can never underflow.
    always_comb begin
        ready = 4'b0000;
        if (!rst && state == LOCK && credit_ok) ready = grant;
    end

    assign xfer = |(bus.req_valid & ready);

    always_comb begin
        sel_data = '0;
        sel_tail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
                sel_tail = bus.req_tail[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 4'b0000;
            last_winner  <= 4'b1000;
            credit       <= CREDIT_FULL;
            credit_err_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_tail_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            out_valid_q <= xfer;
            out_tail_q  <= xfer & sel_tail;
            if (xfer) out_data_q <= sel_data;

            case (state)
                IDLE: begin
                    if (|bus.req_valid && credit_ok) begin
                        grant <= pick;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (xfer && sel_tail) begin
                        last_winner <= grant;
                        grant       <= 4'b0000;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A return that cannot be absorbed is a downstream protocol error.
            case ({xfer, bus.credit_return})
                2'b10: credit <= credit - 1'b1;
                2'b01: begin
                    if (credit == CREDIT_FULL) credit_err_q <= 1'b1;
                    else                       credit <= credit + 1'b1;
                end
                default: credit <= credit;
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_tail    = out_tail_q;
    assign bus.out_src_sel = onehot4_to_idx(grant);
    assign bus.credit_cnt  = credit;
    assign bus.credit_err  = credit_err_q;
    assign dbg_state       = state;

endmodule
